snake_engine: RTL
=================

# snake_engine

Parametrised snake movement and rendering engine. It holds up to MAXLEN body segments on a cell grid, latches a direction from the four move inputs, and advances one cell per `tick`. It detects apple, wall and self collisions. Each move is rendered incrementally: the tail cell is erased and the new head cell is drawn, as a pixel-plot stream into the 160x120 `vga_adapter`. It replaces the single-square mover in the top level; apple drawing and placement stay in separate blocks.

## Interface
- `CELL`, 4: cell edge in pixels.
- `GX`, 40: grid width in cells.
- `GY`, 30: grid height in cells.
- `MAXLEN`, 16: maximum segment count, 2..64.
- `START_X`, 10: initial head cell x.
- `START_Y`, 15: initial head cell y.
- `SNAKE_COL`, 3'b010: body colour.
- `BG_COL`, 3'b000: erase colour.

Ports:
- `Clock` in 1: system clock, CLOCK_50.
- `Reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle move strobe.
- `enable` in 1: when 0, ticks are ignored.
- `move_right` in 1: level direction request.
- `move_down` in 1: level direction request.
- `move_up` in 1: level direction request.
- `move_left` in 1: level direction request.
- `apple_x` in 6: apple cell x.
- `apple_y` in 5: apple cell y.
- `x` out 8: pixel x to adapter.
- `y` out 7: pixel y to adapter.
- `colour` out 3: pixel colour.
- `plot` out 1: pixel write strobe.
- `head_x` out 6: current head cell x.
- `head_y` out 5: current head cell y.
- `length` out 7: current segment count.
- `ate` out 1: one-cycle pulse on apple eaten.
- `dead` out 1: sticky collision flag.
- `busy` out 1: high whenever state is not WAIT.

## Operation
- Direction encoding: 0 right, 1 down, 2 up, 3 left.
- `dir_req` updates every cycle from the move inputs with priority right > down > up > left. With no input asserted it holds its value.
- A request that reverses `dir` (right/left or up/down) is discarded.
- `dir` takes the value of `dir_req` only in CALC.
- Segment store: `seg[0]` is the head and `seg[length-1]` is the tail. Entries at index `length` and above are don't-care.
- States:
  - INIT: draw head cell in SNAKE_COL, then go to WAIT.
  - WAIT: on `tick && enable`, go to CALC.
  - CALC (1 cycle): compute next head `nh = seg[0] + dir`.
    - wall = `nh` would leave [0,GX-1] x [0,GY-1]. Evaluate before any wrap; the grid never wraps.
    - grow = (`nh` == apple).
    - self = `nh` equals any `seg[i]` for i < `length`. The tail is excluded when not growing, because it vacates this move.
    - wall or self: go to DEAD.
    - grow: go to SHIFT.
    - otherwise: go to ERASE.
  - ERASE: plot tail cell in BG_COL, then go to SHIFT.
  - SHIFT (1 cycle):
    - `seg[i] <= seg[i-1]`, `seg[0] <= nh`.
    - On grow, `length` increments, saturating at MAXLEN.
    - `ate` = grow for this cycle only.
    - If grow and `length == MAXLEN`, the tail is not erased and is dropped from the store. A stale pixel cell remains on screen; this is accepted.
    - Next state: DRAW.
  - DRAW: plot new head cell in SNAKE_COL, then go to WAIT.
  - DEAD: `dead` = 1, `plot` = 0. Stays here until Reset; ticks and moves are ignored.
- Cell plot: `x = cx*CELL + px`, `y = cy*CELL + py`. `px` and `py` count 0..CELL-1, `px` fastest (raster order). One pixel per cycle with `plot` = 1.
- Width rule: GX*CELL ≤ 160 and GY*CELL ≤ 120, so no truncation occurs.

## Timing
- Reset, sampled at a rising edge, gives:
  - state INIT, `length` = 1, `seg[0]` = (START_X, START_Y), `dir` = `dir_req` = right.
  - `dead` = `ate` = `plot` = 0, `x` = `y` = `colour` = 0.
- Reset has priority over all other inputs in every state, including mid-cell-plot.
- INIT lasts CELL² cycles.
- Normal move: tick to WAIT takes 1 + CELL² + 1 + CELL² cycles (34 at CELL=4).
- Growing move takes 2 + CELL² cycles (18).
- Collision: DEAD is entered 1 cycle after the tick is accepted; `dead` is high from the next cycle.
- Ticks arriving while `busy` = 1 are dropped, not queued.
- `head_x`, `head_y` and `length` update on the SHIFT edge.
- `x`, `y`, `colour` and `plot` are registered and valid in the same cycle.

## Test plan
- Reset, then idle: exactly 16 plots at x 40..43, y 60..63 in SNAKE_COL. `busy` falls on cycle 17.
- Tick with no key pressed: 16 BG_COL plots at (40..43, 60..63), then 16 SNAKE_COL plots at (44..47, 60..63). `head_x` = 11.
- Apple at (11,15) and tick: `ate` pulses once, `length` = 2, no BG plots occur, and 18 cycles elapse tick-to-WAIT.
- Heading right, assert `move_left` then tick: direction stays right and `head_x` increments.
- Assert `move_up` then tick: `head_y` = 14.
- Drive the head to x = 39, then tick: `dead` = 1, no plots, and further ticks are ignored.
- Length 5, steer into its own body: `dead` = 1.
- With length 2, a move into the vacating tail cell does not kill.
- Assert Reset during DRAW at pixel 7: the next cycle shows state INIT, `length` = 1 and `plot` = 0, and the initial head redraw follows.

Source files
------------

// File: rtl/snake_engine_if.sv
// Snake engine bus: controls and apple position in, pixel stream and status out.
interface snake_engine_if;
  logic       tick;
  logic       enable;
  logic       move_right;
  logic       move_down;
  logic       move_up;
  logic       move_left;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [6:0] length;
  logic       ate;
  logic       dead;
  logic       busy;

  // Controller side: drives moves and ticks, consumes pixels and status.
  modport master (
    output tick, enable, move_right, move_down, move_up, move_left, apple_x, apple_y,
    input  x, y, colour, plot, head_x, head_y, length, ate, dead, busy
  );

  // Engine side.
  modport slave (
    input  tick, enable, move_right, move_down, move_up, move_left, apple_x, apple_y,
    output x, y, colour, plot, head_x, head_y, length, ate, dead, busy
  );
endinterface

// File: rtl/snake_engine.sv
// Snake movement and incremental renderer: erases the tail cell and draws the new head
// cell as a raster pixel stream for a 160x120 frame buffer.
module snake_engine #(
  parameter int unsigned CELL      = 4,
  parameter int unsigned GX        = 40,
  parameter int unsigned GY        = 30,
  parameter int unsigned MAXLEN    = 16,
  parameter int unsigned START_X   = 10,
  parameter int unsigned START_Y   = 15,
  parameter logic [2:0]  SNAKE_COL = 3'b010,
  parameter logic [2:0]  BG_COL    = 3'b000
) (
  input logic           Clock,
  input logic           Reset,
  snake_engine_if.slave eng
);

  localparam int unsigned IdxW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int unsigned CntW = (CELL > 1) ? $clog2(CELL) : 1;

  typedef enum logic [2:0] {
    StInit, StWait, StCalc, StErase, StShift, StDraw, StDead
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      seg_x [MAXLEN];
  logic [4:0]      seg_y [MAXLEN];
  logic [6:0]      len_q;
  logic [1:0]      dir_q, dir_req_q, req;
  logic            req_valid;
  logic [5:0]      nh_x, nh_x_q;
  logic [4:0]      nh_y, nh_y_q;
  logic            grow, grow_q, wall, self_hit;
  int              lim;
  logic [CntW-1:0] px_q, py_q;
  logic            cell_last, plotting;
  logic [IdxW-1:0] tail_idx;
  logic [5:0]      cx;
  logic [4:0]      cy;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [2:0]      colour_q;
  logic            plot_q;

  assign cell_last = (px_q == CntW'(CELL - 1)) && (py_q == CntW'(CELL - 1));
  assign plotting  = (state_q == StInit) || (state_q == StErase) || (state_q == StDraw);
  assign tail_idx  = IdxW'(len_q - 7'd1);
  assign cx        = (state_q == StErase) ? seg_x[tail_idx] : seg_x[0];
  assign cy        = (state_q == StErase) ? seg_y[tail_idx] : seg_y[0];

  // Priority-encode the level move inputs into a direction request.
  always_comb begin
    req       = 2'd0;
    req_valid = 1'b1;
    if (eng.move_right)     req = 2'd0;
    else if (eng.move_down) req = 2'd1;
    else if (eng.move_up)   req = 2'd2;
    else if (eng.move_left) req = 2'd3;
    else                    req_valid = 1'b0;
  end

  // Next head, wall test on the unwrapped position, apple and body hit tests.
  always_comb begin
    nh_x = seg_x[0];
    nh_y = seg_y[0];
    wall = 1'b0;
    unique case (dir_req_q)
      2'd0: begin wall = (seg_x[0] == 6'(GX - 1)); nh_x = seg_x[0] + 6'd1; end
      2'd1: begin wall = (seg_y[0] == 5'(GY - 1)); nh_y = seg_y[0] + 5'd1; end
      2'd2: begin wall = (seg_y[0] == 5'd0);       nh_y = seg_y[0] - 5'd1; end
      default: begin wall = (seg_x[0] == 6'd0);    nh_x = seg_x[0] - 6'd1; end
    endcase
    grow = (nh_x == eng.apple_x) && (nh_y == eng.apple_y);
    // The tail vacates on a plain move, so it only counts when growing.
    lim = grow ? int'(len_q) : int'(len_q) - 1;
    self_hit = 1'b0;
    for (int i = 0; i < MAXLEN; i++) begin
      if ((i < lim) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y)) self_hit = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= StInit;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (cell_last) state_d = StWait;
      StWait:  if (eng.tick && eng.enable) state_d = StCalc;
      StCalc: begin
        if (wall || self_hit) state_d = StDead;
        else if (grow)        state_d = StShift;
        else                  state_d = StErase;
      end
      StErase: if (cell_last) state_d = StShift;
      StShift: state_d = StDraw;
      StDraw:  if (cell_last) state_d = StWait;
      default: state_d = StDead;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    eng.busy = (state_q != StWait);
    eng.ate  = (state_q == StShift) && grow_q;
    eng.dead = (state_q == StDead);
  end

  // Direction latch, segment store, length and pixel counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < MAXLEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0]  <= 6'(START_X);
      seg_y[0]  <= 5'(START_Y);
      len_q     <= 7'd1;
      dir_q     <= 2'd0;
      dir_req_q <= 2'd0;
      nh_x_q    <= '0;
      nh_y_q    <= '0;
      grow_q    <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
    end else begin
      // Opposite directions differ in both bits (0/3, 1/2).
      if (req_valid && (state_q != StDead) && ((req ^ dir_q) != 2'd3)) dir_req_q <= req;
      if (state_q == StCalc) begin
        dir_q  <= dir_req_q;
        nh_x_q <= nh_x;
        nh_y_q <= nh_y;
        grow_q <= grow;
      end
      if (state_q == StShift) begin
        for (int i = MAXLEN - 1; i > 0; i--) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= nh_x_q;
        seg_y[0] <= nh_y_q;
        if (grow_q && (len_q < 7'(MAXLEN))) len_q <= len_q + 7'd1;
      end
      if (plotting) begin
        if (px_q == CntW'(CELL - 1)) begin
          px_q <= '0;
          py_q <= (py_q == CntW'(CELL - 1)) ? '0 : py_q + CntW'(1);
        end else begin
          px_q <= px_q + CntW'(1);
        end
      end
    end
  end

  // Registered pixel stream.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      if (plotting) begin
        plot_q   <= 1'b1;
        x_q      <= 8'(int'(cx) * CELL + int'(px_q));
        y_q      <= 7'(int'(cy) * CELL + int'(py_q));
        colour_q <= (state_q == StErase) ? BG_COL : SNAKE_COL;
      end
    end
  end

  assign eng.x      = x_q;
  assign eng.y      = y_q;
  assign eng.colour = colour_q;
  assign eng.plot   = plot_q;
  assign eng.head_x = seg_x[0];
  assign eng.head_y = seg_y[0];
  assign eng.length = len_q;

endmodule
